// File: rtl/alu_reservation_station.sv
// alu_reservation_station: a collapsing-queue reservation station in front of
// the arithmetic execute unit. It captures operands and NZCV from the CDB and
// issues the oldest fully ready micro-op through a registered valid/ready stage.
module alu_reservation_station #(
   parameter int  NUM_ENTRIES = 4,
   parameter int  TAG_WIDTH   = 4,
   parameter int  GPR_SIZE    = 32,
   parameter type alu_op_t    = logic [3:0],
   parameter type cond_t      = logic [3:0],
   parameter type nzcv_t      = logic [3:0]
) (
   input  logic                               in_clk,
   input  logic                               in_rst_n,
   input  logic                               in_flush,
   input  logic                               in_dispatch_valid,
   output logic                               out_dispatch_ready,
   input  alu_op_t                            in_alu_op,
   input  logic [5:0]                         in_alu_val_hw,
   input  logic                               in_set_CC,
   input  cond_t                              in_cond,
   input  logic [TAG_WIDTH-1:0]               in_dst_tag,
   input  logic [GPR_SIZE-1:0]                in_val_a,
   input  logic [GPR_SIZE-1:0]                in_val_b,
   input  logic                               in_a_ready,
   input  logic                               in_b_ready,
   input  logic [TAG_WIDTH-1:0]               in_a_tag,
   input  logic [TAG_WIDTH-1:0]               in_b_tag,
   input  nzcv_t                              in_nzcv,
   input  logic                               in_nzcv_ready,
   input  logic [TAG_WIDTH-1:0]               in_nzcv_tag,
   input  logic                               in_cdb_valid,
   input  logic [TAG_WIDTH-1:0]               in_cdb_tag,
   input  logic [GPR_SIZE-1:0]                in_cdb_val,
   input  logic                               in_cdb_set_nzcv,
   input  nzcv_t                              in_cdb_nzcv,
   output logic                               out_issue_valid,
   input  logic                               in_issue_ready,
   output alu_op_t                            out_alu_op,
   output logic [GPR_SIZE-1:0]                out_val_a,
   output logic [GPR_SIZE-1:0]                out_val_b,
   output logic [5:0]                         out_alu_val_hw,
   output logic                               out_set_CC,
   output cond_t                              out_cond,
   output nzcv_t                              out_prev_nzcv,
   output logic [TAG_WIDTH-1:0]               out_dst_tag,
   output logic [$clog2(NUM_ENTRIES+1)-1:0]   out_occupancy
);
   localparam int OCC_W = $clog2(NUM_ENTRIES + 1);
   localparam int IDX_W = $clog2(NUM_ENTRIES);
   localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(NUM_ENTRIES);

   typedef struct packed {
      logic                 valid;
      alu_op_t              op;
      logic [5:0]           hw;
      logic                 set_cc;
      cond_t                cond;
      logic [TAG_WIDTH-1:0] dst;
      logic                 a_rdy;
      logic [TAG_WIDTH-1:0] a_tag;
      logic [GPR_SIZE-1:0]  a_val;
      logic                 b_rdy;
      logic [TAG_WIDTH-1:0] b_tag;
      logic [GPR_SIZE-1:0]  b_val;
      logic                 f_rdy;
      logic [TAG_WIDTH-1:0] f_tag;
      nzcv_t                f_val;
   } entry_t;

   entry_t               ent_r     [NUM_ENTRIES];
   entry_t               ent_w_s   [NUM_ENTRIES];
   entry_t               ent_sh_s  [NUM_ENTRIES];
   entry_t               ent_nxt_s [NUM_ENTRIES];
   entry_t               disp_raw_s;
   entry_t               disp_ent_s;
   logic [NUM_ENTRIES-1:0] rdy_s;
   logic                 sel_found_s;
   logic [IDX_W-1:0]     sel_idx_s;
   logic                 load_s;
   logic                 disp_s;
   logic [OCC_W-1:0]     occ_rm_s;
   logic [OCC_W-1:0]     occ_nxt_s;

   // Capture any waiting operand or flags whose producer tag is on the CDB
   function automatic entry_t wake(input entry_t e, input logic cv,
                                   input logic [TAG_WIDTH-1:0] ct,
                                   input logic [GPR_SIZE-1:0] cval,
                                   input logic cset, input nzcv_t cn);
      entry_t w;
      w = e;
      if (cv && !e.a_rdy && (e.a_tag == ct)) begin
         w.a_rdy = 1'b1;
         w.a_val = cval;
      end else begin
         w.a_rdy = e.a_rdy;
      end
      if (cv && !e.b_rdy && (e.b_tag == ct)) begin
         w.b_rdy = 1'b1;
         w.b_val = cval;
      end else begin
         w.b_rdy = e.b_rdy;
      end
      if (cv && cset && !e.f_rdy && (e.f_tag == ct)) begin
         w.f_rdy = 1'b1;
         w.f_val = cn;
      end else begin
         w.f_rdy = e.f_rdy;
      end
      return w;
   endfunction

   // Build the dispatched entry and apply CDB wakeup to stored and new entries
   always_comb begin
      disp_raw_s = '{valid: 1'b1, op: in_alu_op, hw: in_alu_val_hw, set_cc: in_set_CC,
                     cond: in_cond, dst: in_dst_tag,
                     a_rdy: in_a_ready, a_tag: in_a_tag, a_val: in_val_a,
                     b_rdy: in_b_ready, b_tag: in_b_tag, b_val: in_val_b,
                     f_rdy: in_nzcv_ready, f_tag: in_nzcv_tag, f_val: in_nzcv};
      disp_ent_s = wake(disp_raw_s, in_cdb_valid, in_cdb_tag, in_cdb_val,
                        in_cdb_set_nzcv, in_cdb_nzcv);
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         ent_w_s[i] = wake(ent_r[i], in_cdb_valid, in_cdb_tag, in_cdb_val,
                           in_cdb_set_nzcv, in_cdb_nzcv);
      end
   end

   // Pick the oldest fully ready entry from registered state only
   always_comb begin
      sel_found_s = 1'b0;
      sel_idx_s   = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         rdy_s[i]    = ent_r[i].valid & ent_r[i].a_rdy & ent_r[i].b_rdy & ent_r[i].f_rdy;
         sel_found_s = sel_found_s | rdy_s[i];
         sel_idx_s   = rdy_s[i] ? IDX_W'(i) : sel_idx_s;
      end
      load_s = sel_found_s & (~out_issue_valid | in_issue_ready);
      disp_s = in_dispatch_valid & out_dispatch_ready & ~in_flush;
   end

   // Collapse the queue over a removed entry, then append the dispatched entry
   always_comb begin
      for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
         ent_sh_s[i] = (load_s && (IDX_W'(i) >= sel_idx_s)) ? ent_w_s[i + 1] : ent_w_s[i];
      end
      ent_sh_s[NUM_ENTRIES-1] = load_s ? '0 : ent_w_s[NUM_ENTRIES-1];
      occ_rm_s  = out_occupancy - {{(OCC_W-1){1'b0}}, load_s};
      occ_nxt_s = occ_rm_s + {{(OCC_W-1){1'b0}}, disp_s};
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         ent_nxt_s[i] = (disp_s && (occ_rm_s == OCC_W'(i))) ? disp_ent_s : ent_sh_s[i];
      end
   end

   // Entry storage; flush drops every entry
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         for (int i = 0; i < NUM_ENTRIES; i++) ent_r[i] <= '0;
      end else if (in_flush) begin
         for (int i = 0; i < NUM_ENTRIES; i++) ent_r[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) ent_r[i] <= ent_nxt_s[i];
      end
   end

   // Occupancy and dispatch-ready, both derived from the next occupancy
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         out_occupancy      <= '0;
         out_dispatch_ready <= 1'b1;
      end else if (in_flush) begin
         out_occupancy      <= '0;
         out_dispatch_ready <= 1'b1;
      end else begin
         out_occupancy      <= occ_nxt_s;
         out_dispatch_ready <= (occ_nxt_s < FULL_OCC);
      end
   end

   // Output stage: load the selected entry when empty or draining, else hold
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         out_issue_valid <= 1'b0;
         out_alu_op      <= '0;
         out_val_a       <= '0;
         out_val_b       <= '0;
         out_alu_val_hw  <= '0;
         out_set_CC      <= 1'b0;
         out_cond        <= '0;
         out_prev_nzcv   <= '0;
         out_dst_tag     <= '0;
      end else if (in_flush) begin
         out_issue_valid <= 1'b0;
      end else if (load_s) begin
         out_issue_valid <= 1'b1;
         out_alu_op      <= ent_r[sel_idx_s].op;
         out_val_a       <= ent_r[sel_idx_s].a_val;
         out_val_b       <= ent_r[sel_idx_s].b_val;
         out_alu_val_hw  <= ent_r[sel_idx_s].hw;
         out_set_CC      <= ent_r[sel_idx_s].set_cc;
         out_cond        <= ent_r[sel_idx_s].cond;
         out_prev_nzcv   <= ent_r[sel_idx_s].f_val;
         out_dst_tag     <= ent_r[sel_idx_s].dst;
      end else if (in_issue_ready) begin
         out_issue_valid <= 1'b0;
      end else begin
         out_issue_valid <= out_issue_valid;
      end
   end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed self-checking bench for alu_reservation_station.
module tb_alu_reservation_station;
   localparam logic [3:0] PLUS  = 4'd0;
   localparam logic [3:0] MINUS = 4'd1;

   logic        clk, rst_n, flush, dispatch_valid, dispatch_ready;
   logic [3:0]  alu_op, cond, dst_tag, a_tag, b_tag, nzcv, nzcv_tag;
   logic [5:0]  alu_val_hw;
   logic        set_cc, a_ready, b_ready, nzcv_ready;
   logic [31:0] val_a, val_b;
   logic        cdb_valid, cdb_set_nzcv;
   logic [3:0]  cdb_tag, cdb_nzcv;
   logic [31:0] cdb_val;
   logic        issue_valid, issue_ready;
   logic [3:0]  o_alu_op, o_cond, o_prev_nzcv, o_dst_tag;
   logic [31:0] o_val_a, o_val_b;
   logic [5:0]  o_hw;
   logic        o_set_cc;
   logic [2:0]  occupancy;
   int          n_checks = 0;
   int          n_pass = 0;

   alu_reservation_station dut (
      .in_clk(clk), .in_rst_n(rst_n), .in_flush(flush),
      .in_dispatch_valid(dispatch_valid), .out_dispatch_ready(dispatch_ready),
      .in_alu_op(alu_op), .in_alu_val_hw(alu_val_hw), .in_set_CC(set_cc), .in_cond(cond),
      .in_dst_tag(dst_tag), .in_val_a(val_a), .in_val_b(val_b),
      .in_a_ready(a_ready), .in_b_ready(b_ready), .in_a_tag(a_tag), .in_b_tag(b_tag),
      .in_nzcv(nzcv), .in_nzcv_ready(nzcv_ready), .in_nzcv_tag(nzcv_tag),
      .in_cdb_valid(cdb_valid), .in_cdb_tag(cdb_tag), .in_cdb_val(cdb_val),
      .in_cdb_set_nzcv(cdb_set_nzcv), .in_cdb_nzcv(cdb_nzcv),
      .out_issue_valid(issue_valid), .in_issue_ready(issue_ready),
      .out_alu_op(o_alu_op), .out_val_a(o_val_a), .out_val_b(o_val_b),
      .out_alu_val_hw(o_hw), .out_set_CC(o_set_cc), .out_cond(o_cond),
      .out_prev_nzcv(o_prev_nzcv), .out_dst_tag(o_dst_tag), .out_occupancy(occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      dispatch_valid = 1'b0;
      cdb_valid      = 1'b0;
      cdb_set_nzcv   = 1'b0;
      cdb_tag        = 4'd0;
      cdb_val        = 32'd0;
      cdb_nzcv       = 4'd0;
      flush          = 1'b0;
   endtask

   task automatic disp(input logic [3:0] op, input logic [3:0] dst,
                       input logic ar, input logic [3:0] at, input logic [31:0] va,
                       input logic br, input logic [3:0] bt, input logic [31:0] vb,
                       input logic fr, input logic [3:0] ft, input logic [3:0] fv);
      dispatch_valid = 1'b1;
      alu_op = op; dst_tag = dst;
      alu_val_hw = 6'd0; set_cc = 1'b0; cond = 4'd0;
      a_ready = ar; a_tag = at; val_a = va;
      b_ready = br; b_tag = bt; val_b = vb;
      nzcv_ready = fr; nzcv_tag = ft; nzcv = fv;
   endtask

   task automatic cdb(input logic [3:0] tag, input logic [31:0] v,
                      input logic setn, input logic [3:0] n);
      cdb_valid = 1'b1; cdb_tag = tag; cdb_val = v; cdb_set_nzcv = setn; cdb_nzcv = n;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      issue_ready = 1'b0;
      set_idle();
      disp(PLUS, 4'd0, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 4'd0);
      dispatch_valid = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      n_checks++; if (issue_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", issue_valid); else n_pass++;
      n_checks++; if (occupancy !== 3'd0) $display("FAIL reset_occ: got %0d want 0", occupancy); else n_pass++;
      n_checks++; if (dispatch_ready !== 1'b1) $display("FAIL reset_dready: got %0b want 1", dispatch_ready); else n_pass++;
      n_checks++; if (o_val_a !== 32'd0) $display("FAIL reset_val_a: got %0h want 0", o_val_a); else n_pass++;
      n_checks++; if (o_dst_tag !== 4'd0) $display("FAIL reset_dst: got %0d want 0", o_dst_tag); else n_pass++;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      issue_ready = 1'b1;
      disp(PLUS, 4'd3, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 4'b1010);
      alu_val_hw = 6'd12; set_cc = 1'b1; cond = 4'd3;
      tick(); set_idle();
      n_checks++; if (issue_valid !== 1'b0) $display("FAIL basic_early: got %0b want 0", issue_valid); else n_pass++;
      n_checks++; if (occupancy !== 3'd1) $display("FAIL basic_occ1: got %0d want 1", occupancy); else n_pass++;
      tick();
      n_checks++; if (issue_valid !== 1'b1) $display("FAIL basic_valid: got %0b want 1", issue_valid); else n_pass++;
      n_checks++; if (o_val_a !== 32'd5) $display("FAIL basic_val_a: got %0h want 5", o_val_a); else n_pass++;
      n_checks++; if (o_val_b !== 32'd7) $display("FAIL basic_val_b: got %0h want 7", o_val_b); else n_pass++;
      n_checks++; if (o_dst_tag !== 4'd3) $display("FAIL basic_dst: got %0d want 3", o_dst_tag); else n_pass++;
      n_checks++; if (o_alu_op !== PLUS) $display("FAIL basic_op: got %0d want %0d", o_alu_op, PLUS); else n_pass++;
      n_checks++; if (o_hw !== 6'd12) $display("FAIL basic_hw: got %0d want 12", o_hw); else n_pass++;
      n_checks++; if (o_set_cc !== 1'b1) $display("FAIL basic_setcc: got %0b want 1", o_set_cc); else n_pass++;
      n_checks++; if (o_cond !== 4'd3) $display("FAIL basic_cond: got %0d want 3", o_cond); else n_pass++;
      n_checks++; if (o_prev_nzcv !== 4'b1010) $display("FAIL basic_nzcv: got %b want 1010", o_prev_nzcv); else n_pass++;
      tick();
      n_checks++; if (issue_valid !== 1'b0) $display("FAIL basic_drop: got %0b want 0", issue_valid); else n_pass++;
      n_checks++; if (occupancy !== 3'd0) $display("FAIL basic_occ0: got %0d want 0", occupancy); else n_pass++;
   endtask

   task automatic test_wakeup();
      issue_ready = 1'b1;
      disp(PLUS, 4'd4, 1'b0, 4'd2, 32'd0, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'd0);
      tick(); set_idle();
      tick();
      n_checks++; if (issue_valid !== 1'b0) $display("FAIL wake_noissue: got %0b want 0", issue_valid); else n_pass++;
      cdb(4'd2, 32'h10, 1'b0, 4'd0);
      tick(); set_idle();
      n_checks++; if (issue_valid !== 1'b0) $display("FAIL wake_bypass: got %0b want 0", issue_valid); else n_pass++;
      tick();
      n_checks++; if (issue_valid !== 1'b1) $display("FAIL wake_valid: got %0b want 1", issue_valid); else n_pass++;
      n_checks++; if (o_val_a !== 32'h10) $display("FAIL wake_val_a: got %0h want 10", o_val_a); else n_pass++;
      n_checks++; if (o_val_b !== 32'd1) $display("FAIL wake_val_b: got %0h want 1", o_val_b); else n_pass++;
      tick();
      // flags wakeup: broadcast without set_nzcv must not wake
      disp(MINUS, 4'd5, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 32'd3, 1'b0, 4'd6, 4'd0);
      tick(); set_idle();
      cdb(4'd6, 32'd0, 1'b0, 4'b1111);
      tick(); set_idle();
      tick();
      n_checks++; if (issue_valid !== 1'b0) $display("FAIL wake_nzcv_noset: got %0b want 0", issue_valid); else n_pass++;
      cdb(4'd6, 32'd0, 1'b1, 4'b0110);
      tick(); set_idle();
      tick();
      n_checks++; if (issue_valid !== 1'b1) $display("FAIL wake_nzcv_valid: got %0b want 1", issue_valid); else n_pass++;
      n_checks++; if (o_prev_nzcv !== 4'b0110) $display("FAIL wake_nzcv_val: got %b want 0110", o_prev_nzcv); else n_pass++;
      n_checks++; if (o_dst_tag !== 4'd5) $display("FAIL wake_nzcv_dst: got %0d want 5", o_dst_tag); else n_pass++;
      tick();
   endtask

   task automatic test_age_order();
      issue_ready = 1'b1;
      disp(PLUS, 4'd1, 1'b0, 4'd5, 32'd0, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 4'd0);
      tick();
      disp(PLUS, 4'd2, 1'b1, 4'd0, 32'h21, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 4'd0);
      tick();
      disp(PLUS, 4'd3, 1'b1, 4'd0, 32'h31, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 4'd0);
      tick(); set_idle();
      n_checks++; if (o_dst_tag !== 4'd2 || issue_valid !== 1'b1) $display("FAIL age_y: got v=%0b dst=%0d want v=1 dst=2", issue_valid, o_dst_tag); else n_pass++;
      tick();
      n_checks++; if (o_dst_tag !== 4'd3 || issue_valid !== 1'b1) $display("FAIL age_z: got v=%0b dst=%0d want v=1 dst=3", issue_valid, o_dst_tag); else n_pass++;
      tick();
      n_checks++; if (issue_valid !== 1'b0) $display("FAIL age_x_wait: got %0b want 0", issue_valid); else n_pass++;
      cdb(4'd5, 32'h55, 1'b0, 4'd0);
      tick(); set_idle();
      tick();
      n_checks++; if (o_dst_tag !== 4'd1 || issue_valid !== 1'b1) $display("FAIL age_x: got v=%0b dst=%0d want v=1 dst=1", issue_valid, o_dst_tag); else n_pass++;
      n_checks++; if (o_val_a !== 32'h55) $display("FAIL age_x_val: got %0h want 55", o_val_a); else n_pass++;
      tick();
      n_checks++; if (occupancy !== 3'd0) $display("FAIL age_occ: got %0d want 0", occupancy); else n_pass++;
   endtask

   task automatic test_backpressure();
      issue_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         disp(MINUS, 4'(i), 1'b1, 4'd0, 32'h100 + 32'(i), 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 4'd0);
         tick();
      end
      n_checks++; if (occupancy !== 3'd4) $display("FAIL bp_occ: got %0d want 4", occupancy); else n_pass++;
      n_checks++; if (dispatch_ready !== 1'b0) $display("FAIL bp_dready: got %0b want 0", dispatch_ready); else n_pass++;
      n_checks++; if (o_dst_tag !== 4'd1 || issue_valid !== 1'b1) $display("FAIL bp_head: got v=%0b dst=%0d want v=1 dst=1", issue_valid, o_dst_tag); else n_pass++;
      disp(MINUS, 4'd6, 1'b1, 4'd0, 32'h106, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 4'd0);
      tick(); set_idle();
      n_checks++; if (occupancy !== 3'd4) $display("FAIL bp_sixth: got %0d want 4", occupancy); else n_pass++;
      n_checks++; if (o_dst_tag !== 4'd1 || o_val_a !== 32'h101) $display("FAIL bp_hold: got dst=%0d a=%0h want dst=1 a=101", o_dst_tag, o_val_a); else n_pass++;
      issue_ready = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         tick();
         n_checks++;
         if (issue_valid !== 1'b1 || o_dst_tag !== 4'(i) || o_val_a !== 32'h100 + 32'(i))
            $display("FAIL bp_order%0d: got v=%0b dst=%0d a=%0h want v=1 dst=%0d", i, issue_valid, o_dst_tag, o_val_a, i);
         else n_pass++;
      end
      tick();
      n_checks++; if (issue_valid !== 1'b0 || occupancy !== 3'd0) $display("FAIL bp_drain: got v=%0b occ=%0d want v=0 occ=0", issue_valid, occupancy); else n_pass++;
   endtask

   task automatic test_race_flush();
      issue_ready = 1'b1;
      disp(PLUS, 4'd8, 1'b0, 4'd7, 32'd0, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 4'd0);
      cdb(4'd7, 32'd9, 1'b0, 4'd0);
      tick(); set_idle();
      tick();
      n_checks++; if (issue_valid !== 1'b1 || o_val_a !== 32'd9) $display("FAIL race: got v=%0b a=%0h want v=1 a=9", issue_valid, o_val_a); else n_pass++;
      tick();
      issue_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         disp(PLUS, 4'(i), 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 4'd0);
         tick();
      end
      n_checks++; if (occupancy !== 3'd3 || issue_valid !== 1'b1) $display("FAIL flush_pre: got occ=%0d v=%0b want occ=3 v=1", occupancy, issue_valid); else n_pass++;
      flush = 1'b1;
      tick(); set_idle();
      n_checks++; if (occupancy !== 3'd0) $display("FAIL flush_occ: got %0d want 0", occupancy); else n_pass++;
      n_checks++; if (issue_valid !== 1'b0) $display("FAIL flush_valid: got %0b want 0", issue_valid); else n_pass++;
      n_checks++; if (dispatch_ready !== 1'b1) $display("FAIL flush_dready: got %0b want 1", dispatch_ready); else n_pass++;
      issue_ready = 1'b1;
      tick();
      tick();
      n_checks++; if (issue_valid !== 1'b0) $display("FAIL flush_stale: got %0b want 0", issue_valid); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wakeup();
      test_age_order();
      test_backpressure();
      test_race_flush();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
